// File: rtl/debug_console_pkg.sv
// Shared definitions for the debug console unit.
// Contents:
//   - register indices (addr[4:2]) for the CPU-visible register map
//   - CSR bit positions and the CSR reset value
//   - a helper that turns a byte address into a register index
package debug_console_pkg;

  localparam logic [2:0] TIMEL = 3'd0;
  localparam logic [2:0] TIMEH = 3'd1;
  localparam logic [2:0] CSR   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] CMPL  = 3'd4;
  localparam logic [2:0] CMPH  = 3'd5;

  localparam int CSR_CLR     = 0;
  localparam int CSR_BLOCK   = 1;
  localparam int CSR_TIE     = 2;
  localparam int CSR_OVF     = 3;
  localparam int CSR_TIP     = 4;
  localparam int CSR_EMPTY   = 5;
  localparam int CSR_FULL    = 6;
  localparam int CSR_CNT_LSB = 16;

  localparam logic [31:0] CSR_RESET = 32'h0000_0020;

  // Registers are word aligned, so the two low address bits never select anything.
  function automatic logic [2:0] reg_index(input logic [4:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/dbg_byte_fifo.sv
// Parametrised synchronous byte FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and byte; refused when full unless a pop frees a slot
//   pop              read request; ignored when empty
//   flush            empties the FIFO, overriding any push or pop in the same cycle
//   head             oldest byte (0 while empty)
//   full, empty      occupancy flags
//   count            number of stored bytes, 0..DEPTH
module dbg_byte_fifo #(
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is still accepted when the same cycle pops a byte out.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Gating with empty keeps the stream data at 0 after reset without resetting the array.
  assign head  = empty ? 8'h00 : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/debug_console_unit.sv
// Debug console unit: memory-mapped timer, timer-compare interrupt and byte FIFO
// that drains through a valid/ready stream.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   addr_i                 byte address, register select in [4:2]
//   wdata_cpu_i, wr_en_i   CPU write
//   rd_en_i                CPU read strobe (registers the address, TIMEL side effect)
//   stall_o                holds the CPU while a blocking DATA write waits for space
//   data_cpu_o             read data, one cycle after rd_en_i
//   tx_data_o, tx_valid_o  FIFO head byte and non-empty flag
//   tx_ready_i             sink ready; a byte pops on tx_valid_o & tx_ready_i
//   irq_o                  registered TIE & TIP
// Optional build macro: DEBUG_CONSOLE_SIM_PRINT_EN adds a simulation-only
// line printer on the popped byte stream.
module debug_console_unit
  import debug_console_pkg::*;
#(
  parameter int FIFO_DEPTH = 128,
  parameter int TIMER_W    = 64,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_cpu_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  output logic        stall_o,
  output logic [31:0] data_cpu_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        irq_o
);

  logic [TIMER_W-1:0] timer_q;
  logic [63:0]        timer64;
  logic [31:0]        timel_q;
  logic [31:0]        timeh_q;
  logic [31:0]        cmpl_q;
  logic [31:0]        cmph_q;
  logic [2:0]         rd_idx_q;
  logic [2:0]         idx;
  logic               block_q, tie_q, ovf_q, tip_q, irq_q;
  logic               tie_next, tip_next;
  logic               csr_wr, data_wr, pop, blocked, flush, match;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [31:0]        csr_val;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign unused_ok = ^addr_i[1:0];

  assign idx     = reg_index(addr_i);
  assign timer64 = 64'(timer_q);
  assign csr_wr  = wr_en_i && (idx == CSR);
  assign data_wr = wr_en_i && (idx == DATA);
  assign pop     = tx_valid_o & tx_ready_i;
  assign flush   = csr_wr & wdata_cpu_i[CSR_CLR];
  assign match   = (timer64 == {cmph_q, cmpl_q});

  // A DATA write that finds no room this cycle either stalls the CPU or is dropped.
  assign blocked = data_wr & fifo_full & ~pop;
  assign stall_o = blocked & block_q;

  dbg_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (data_wr),
    .push_data (wdata_cpu_i[7:0]),
    .pop       (pop),
    .flush     (flush),
    .head      (tx_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid_o = ~fifo_empty;

  // A compare match beats a simultaneous write-1-to-clear of TIP.
  always_comb begin
    tie_next = tie_q;
    tip_next = tip_q;
    if (csr_wr) begin
      tie_next = wdata_cpu_i[CSR_TIE];
      if (wdata_cpu_i[CSR_TIP]) tip_next = 1'b0;
    end
    if (match) tip_next = 1'b1;
  end

  // Timer and CSR state; irq follows the same-edge TIE/TIP values so it is TIE & TIP delayed by nothing but the register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      block_q <= CSR_RESET[CSR_BLOCK];
      tie_q   <= CSR_RESET[CSR_TIE];
      ovf_q   <= CSR_RESET[CSR_OVF];
      tip_q   <= CSR_RESET[CSR_TIP];
      irq_q   <= 1'b0;
      cmpl_q  <= '1;
      cmph_q  <= '1;
    end else begin
      timer_q <= timer_q + 1'b1;
      tie_q   <= tie_next;
      tip_q   <= tip_next;
      irq_q   <= tie_next & tip_next;
      if (csr_wr) block_q <= wdata_cpu_i[CSR_BLOCK];
      if (blocked && !block_q) begin
        ovf_q <= 1'b1;
      end else if (csr_wr && wdata_cpu_i[CSR_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (wr_en_i && idx == CMPL) cmpl_q <= wdata_cpu_i;
      if (wr_en_i && idx == CMPH) cmph_q <= wdata_cpu_i;
    end
  end

  // Reading TIMEL latches the whole timer so a following TIMEH read returns the matching upper half.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_idx_q <= TIMEL;
      timel_q  <= '0;
      timeh_q  <= '0;
    end else if (rd_en_i) begin
      rd_idx_q <= idx;
      if (idx == TIMEL) begin
        timel_q <= timer64[31:0];
        timeh_q <= timer64[63:32];
      end
    end
  end

  always_comb begin
    csr_val                = '0;
    csr_val[CSR_BLOCK]     = block_q;
    csr_val[CSR_TIE]       = tie_q;
    csr_val[CSR_OVF]       = ovf_q;
    csr_val[CSR_TIP]       = tip_q;
    csr_val[CSR_EMPTY]     = fifo_empty;
    csr_val[CSR_FULL]      = fifo_full;
    csr_val[31:CSR_CNT_LSB] = 16'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    case (rd_idx_q)
      TIMEL:   rdata = timel_q;
      TIMEH:   rdata = timeh_q;
      CSR:     rdata = csr_val;
      DATA:    rdata = 32'(fifo_count);
      CMPL:    rdata = cmpl_q;
      CMPH:    rdata = cmph_q;
      default: rdata = '0;
    endcase
  end

  assign data_cpu_o = rdata;
  assign irq_o      = irq_q;

`ifdef DEBUG_CONSOLE_SIM_PRINT_EN
  // Collects popped bytes into text lines for the simulation log.
  string line_buf = "";
  always @(posedge clk_i) begin
    if (rst_ni && pop) begin
      if (tx_data_o == 8'h0A) begin
        $display("debug_printf: %s", line_buf);
        line_buf = "";
      end else begin
        line_buf = $sformatf("%s%c", line_buf, tx_data_o);
        if (line_buf.len() >= 128) begin
          $display("debug_printf: %s", line_buf);
          line_buf = "";
        end
      end
    end
  end
`else
  // Without the print option the byte stream is only visible on the tx port.
`endif

endmodule

// File: tb/tb_debug_console_unit.sv
// Self-checking bench for debug_console_unit: queue-based reference of the FIFO
// contents, a negedge monitor that scores every popped byte, and register reads
// checked against expectations computed from the register rules.
module tb_debug_console_unit;

  localparam int DEPTH = 128;
  localparam logic [4:0] A_TIMEL = 5'd0;
  localparam logic [4:0] A_TIMEH = 5'd4;
  localparam logic [4:0] A_CSR   = 5'd8;
  localparam logic [4:0] A_DATA  = 5'd12;
  localparam logic [4:0] A_CMPL  = 5'd16;
  localparam logic [4:0] A_CMPH  = 5'd20;

  logic        clk;
  logic        rst_n;
  logic [4:0]  addr_i;
  logic [31:0] wdata_cpu_i;
  logic        wr_en_i;
  logic        rd_en_i;
  logic        stall_o;
  logic [31:0] data_cpu_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        irq_o;

  int          total;
  int          bad;
  bit          skip_mon;
  logic [63:0] cyc;
  logic [63:0] t_off;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_b;
  bit          m_block, m_tie, m_ovf, m_tip;

  debug_console_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .addr_i      (addr_i),
    .wdata_cpu_i (wdata_cpu_i),
    .wr_en_i     (wr_en_i),
    .rd_en_i     (rd_en_i),
    .stall_o     (stall_o),
    .data_cpu_o  (data_cpu_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the timer should equal this plus any forced offset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [63:0] tnow();
    return cyc + t_off;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Scores each byte leaving the FIFO against the oldest byte the model holds.
  always @(negedge clk) begin
    if (rst_n && !skip_mon && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL tx_byte: got 0x%02h, expected no byte", tx_data_o);
      end else begin
        mon_b = exp_q.pop_front();
        checkOutput("tx_byte", {24'h0, tx_data_o}, {24'h0, mon_b});
      end
    end
  end

  function automatic logic [31:0] csrExp();
    logic [31:0] v;
    int n;
    n = exp_q.size();
    v = 32'h0;
    v[31:16] = 16'(n);
    v[6] = (n == DEPTH);
    v[5] = (n == 0);
    v[4] = m_tip;
    v[3] = m_ovf;
    v[2] = m_tie;
    v[1] = m_block;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [4:0] a,
                               input logic [31:0] d, input logic rdy);
    wr_en_i     = wr;
    rd_en_i     = rd;
    addr_i      = a;
    wdata_cpu_i = d;
    tx_ready_i  = rdy;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic readReg(input logic [4:0] a, input logic [31:0] expv, input string name);
    applyStimulus(1'b0, 1'b1, a, 32'h0, 1'b0);
    tick();
    idle();
    checkOutput(name, data_cpu_o, expv);
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 1'b0);
    tick();
    idle();
  endtask

  task automatic writeCsr(input logic [31:0] v, input logic rdy);
    m_block = v[1];
    m_tie   = v[2];
    if (v[3]) m_ovf = 1'b0;
    if (v[4]) m_tip = 1'b0;
    if (v[0]) begin
      skip_mon = 1'b1;
      exp_q.delete();
    end
    applyStimulus(1'b1, 1'b0, A_CSR, v, rdy);
    tick();
    idle();
    skip_mon = 1'b0;
  endtask

  // A DATA write when no stall is expected: accepted if there is room or a pop, else dropped.
  task automatic pushByte(input logic [7:0] b, input logic rdy);
    bit pop_now;
    pop_now = (exp_q.size() > 0) && rdy;
    applyStimulus(1'b1, 1'b0, A_DATA, {24'h0, b}, rdy);
    if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(b);
    else m_ovf = 1'b1;
    #1;
    checkOutput("no_stall", {31'h0, stall_o}, 32'h0);
    tick();
    idle();
  endtask

  task automatic drainAll(input int bound);
    int n;
    n = 0;
    tx_ready_i = 1'b1;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput("drain_left", exp_q.size(), 32'h0);
    checkOutput("drain_valid", {31'h0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] t;
    logic [63:0] target;
    int guard;
    total = 0; bad = 0; skip_mon = 0; t_off = '0;
    m_block = 0; m_tie = 0; m_ovf = 0; m_tip = 0;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset checks");
    checkOutput("rst_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("rst_data", data_cpu_o, 32'h0);
    checkOutput("rst_valid", {31'h0, tx_valid_o}, 32'h0);
    checkOutput("rst_txdata", {24'h0, tx_data_o}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq_o}, 32'h0);
    rst_n = 1'b1;
    tick();
    t = tnow();
    readReg(A_TIMEL, t[31:0], "timel_live");
    readReg(A_TIMEH, 32'h0, "timeh_rst");
    readReg(A_CSR, 32'h0000_0020, "csr_rst");
    readReg(5'd11, 32'h0000_0020, "csr_lowbits");
    readReg(A_DATA, 32'h0, "data_rst");
    readReg(A_CMPL, 32'hFFFF_FFFF, "cmpl_rst");
    readReg(A_CMPH, 32'hFFFF_FFFF, "cmph_rst");
    readReg(5'd24, 32'h0, "unmapped6");
    writeReg(5'd28, 32'hDEAD_BEEF);
    readReg(5'd28, 32'h0, "unmapped7");

    $display("[TB] overflow fill, drop mode");
    for (int i = 0; i < 130; i++) pushByte(8'(i), 1'b0);
    readReg(A_CSR, csrExp(), "csr_full_ovf");
    readReg(A_DATA, 32'd128, "data_count128");
    drainAll(400);
    writeCsr(32'h8, 1'b0);
    readReg(A_CSR, csrExp(), "csr_ovf_clr");

    $display("[TB] blocking stall");
    writeCsr(32'h2, 1'b0);
    for (int i = 0; i < DEPTH; i++) pushByte(8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, A_DATA, 32'h0000_00AA, 1'b0);
    #1;
    checkOutput("stall_high", {31'h0, stall_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_held", {31'h0, stall_o}, 32'h1);
    end
    tx_ready_i = 1'b1;
    exp_q.push_back(8'hAA);
    #1;
    checkOutput("stall_release", {31'h0, stall_o}, 32'h0);
    tick();
    idle();
    readReg(A_CSR, csrExp(), "csr_after_stall");
    drainAll(400);

    $display("[TB] full with simultaneous pop, flush with pop");
    writeCsr(32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) pushByte(8'($urandom), 1'b0);
    pushByte(8'h5C, 1'b1);
    readReg(A_CSR, csrExp(), "csr_full_pop");
    writeCsr(32'h1, 1'b1);
    readReg(A_CSR, 32'h0000_0020, "csr_flushed");
    checkOutput("flush_valid", {31'h0, tx_valid_o}, 32'h0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      logic rdy;
      rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) pushByte(8'($urandom), rdy);
      else begin
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, rdy);
        tick();
        idle();
      end
      if (c % 80 == 79) readReg(A_CSR, csrExp(), "csr_random");
    end
    drainAll(400);
    writeCsr(32'h8, 1'b0);
    readReg(A_CSR, csrExp(), "csr_random_end");

    $display("[TB] timer compare interrupt");
    writeCsr(32'h4, 1'b0);
    target = tnow() + 30;
    writeReg(A_CMPL, target[31:0]);
    writeReg(A_CMPH, target[63:32]);
    readReg(A_CMPL, target[31:0], "cmpl_rw");
    guard = 0;
    while (tnow() < target && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("irq_before", {31'h0, irq_o}, 32'h0);
    tick();
    checkOutput("irq_rise", {31'h0, irq_o}, 32'h1);
    m_tip = 1'b1;
    readReg(A_CSR, csrExp(), "csr_tip");
    writeCsr(32'h14, 1'b0);
    checkOutput("irq_fall", {31'h0, irq_o}, 32'h0);
    readReg(A_CSR, csrExp(), "csr_tip_clr");
    target = tnow() + 20;
    writeReg(A_CMPL, target[31:0]);
    guard = 0;
    while (tnow() < target && guard < 100) begin
      tick();
      guard++;
    end
    writeCsr(32'h14, 1'b0);
    m_tip = 1'b1;
    checkOutput("irq_w1c_race", {31'h0, irq_o}, 32'h1);
    readReg(A_CSR, csrExp(), "csr_w1c_race");
    writeCsr(32'h10, 1'b0);
    checkOutput("irq_tie_off", {31'h0, irq_o}, 32'h0);

    $display("[TB] timer wrap coherency");
    force dut.timer_q = 64'h0000_0000_FFFF_FFFE;
    t_off = 64'h0000_0000_FFFF_FFFE - cyc;
    #1;
    release dut.timer_q;
    tick();
    t = tnow();
    checkOutput("force_model", t[31:0], 32'hFFFF_FFFF);
    readReg(A_TIMEL, 32'hFFFF_FFFF, "timel_wrap");
    readReg(A_TIMEH, 32'h0, "timeh_wrap");
    t = tnow();
    readReg(A_TIMEL, t[31:0], "timel_after");
    readReg(A_TIMEH, t[63:32], "timeh_after");

    $display("[TB] reset mid-transfer");
    for (int i = 0; i < 5; i++) pushByte(8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, A_DATA, 32'h77, 1'b1);
    #2;
    skip_mon = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    t_off = '0;
    m_block = 0; m_tie = 0; m_ovf = 0; m_tip = 0;
    #1;
    checkOutput("midrst_valid", {31'h0, tx_valid_o}, 32'h0);
    checkOutput("midrst_txdata", {24'h0, tx_data_o}, 32'h0);
    checkOutput("midrst_data", data_cpu_o, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    skip_mon = 1'b0;
    readReg(A_CSR, 32'h0000_0020, "csr_after_rst");
    readReg(A_DATA, 32'h0, "data_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
